ahb_timer_slave: RTL and testbench
==================================

Name: ahb_timer_slave

Overview:
- AHB-lite responder on the slave side of `ahb_lite`, alongside `uart_top` and `ram_top`.
- Uses the same slave port set: `haddr_m2s`/`hwdata_m2s`/`hwrite_m2s` in, `hsel` in, `hready`/`hresp`/`hrdata` out.
- Implements a 64-bit machine timer: `mtime`, `mtimecmp`, control and prescaler registers.
- Raises a level timer interrupt toward the core.
- Supports configurable wait states and the two-cycle AHB error response.

Parameters:
- `AHB_ADDR_WIDTH`, 32, address width; only `haddr[7:0]` is decoded.
- `AHB_DATA_WIDTH`, 32, data width; fixed at 32, other values unsupported.
- `WAIT_CYCLES`, 0, number of `hready`=0 cycles inserted before every OKAY response (0..15).
- `PRESCALE_RST`, 0, reset value of PRESCALE.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; synchronous, active-high (1 = reset)
- `haddr`  in  AHB_ADDR_WIDTH  transfer address (address phase)
- `hwrite`  in  1  1 = write, 0 = read (address phase)
- `hwdata`  in  AHB_DATA_WIDTH  write data (data phase)
- `hsel`  in  1  slave select from fabric decoder
- `hready`  out  1  1 = data phase completes this cycle
- `hresp`  out  1  0 = OKAY, 1 = ERROR
- `hrdata`  out  AHB_DATA_WIDTH  read data
- `timer_irq`  out  1  registered level interrupt

Behaviour:
- Reset values (`rstn`=1 at an edge):
  - Outputs: `hready`=1, `hresp`=0, `hrdata`=0, `timer_irq`=0.
  - Registers: `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=PRESCALE_RST, prescale counter=0.
  - Reset mid-transfer aborts the transfer; state returns to IDLE and a pending write is dropped.
- Register map (byte offset `haddr[7:0]`):
  - 0x00 MTIME_LO, 0x04 MTIME_HI: RW.
  - 0x08 CMP_LO, 0x0C CMP_HI: RW.
  - 0x10 CTRL: bit0 EN, bit1 IE; other bits read 0, writes ignored.
  - 0x14 PRESCALE: bits[15:0]; upper bits read 0.
  - 0x18 STATUS: bit0 = (`mtime` >= `mtimecmp`); read-only, writes ignored with OKAY.
- Illegal access = `haddr[1:0]`≠0 or offset not in the map. Response is ERROR; writes have no effect.
- FSM states:
  - IDLE: `hready`=1, `hresp`=0.
  - WAIT: `hready`=0, `hresp`=0; counter runs WAIT_CYCLES cycles.
  - RESP: `hready`=1, `hresp`=0.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
- Address-phase acceptance:
  - Occurs at an edge where state ∈ {IDLE, RESP, ERR2} and `hsel`=1.
  - Latches `haddr[7:0]` and `hwrite`.
  - Next state: ERR1 if illegal, else WAIT if WAIT_CYCLES>0, else RESP.
- In those three states with `hsel`=0, the next state is IDLE.
- WAIT → RESP after WAIT_CYCLES cycles. ERR1 → ERR2 always. `hsel` is ignored in WAIT and ERR1.
- Read:
  - `hrdata` is loaded with the addressed register value at the edge entering RESP.
  - It holds until the next read entering RESP; it is not cleared by writes or errors.
- Write:
  - `hwdata` is sampled at the edge ending RESP.
  - The register updates at that edge and is visible to a read accepted at that same edge.
- Latency at WAIT_CYCLES=0: address accepted at edge N → RESP during cycle N+1 → one transfer per cycle when back-to-back.
- Latency in general: WAIT_CYCLES+1 cycles per OKAY transfer; 2 cycles per ERROR transfer.
- Timer counting:
  - When EN=1, the prescale counter counts 0..PRESCALE.
  - At the edge where counter==PRESCALE, `mtime` increments by 1 and the counter returns to 0.
  - PRESCALE=0 means increment every cycle.
  - EN=0 freezes both `mtime` and the counter.
  - Writing PRESCALE resets the counter to 0.
  - `mtime` wraps from 2^64-1 to 0.
- Simultaneous software write and increment:
  - A write to MTIME_LO or MTIME_HI takes priority: the written half takes `hwdata`.
  - The other half holds, with no increment and no carry that cycle.
- `timer_irq` is registered: next value = IE & (`mtime` >= `mtimecmp`), using the current-cycle register values (unsigned 64-bit compare).
- Writing `mtimecmp` above `mtime` deasserts `timer_irq` within 2 edges.

Test Plan:
- Reset with WAIT_CYCLES=0, then read 0x0C → `hrdata`=32'hFFFF_FFFF, `hresp`=0, `hready`=1 in the cycle after the address phase; read 0x10 → 0.
- Write CTRL=1, PRESCALE=3; after the enable write completes, read MTIME_LO every 20 cycles → value increases by 5 per read (±1 depending on sample phase).
- Write MTIME_LO=FFFF_FFFF and MTIME_HI=0, then EN=1, PRESCALE=0 → after 1 increment, MTIME_LO=0 and MTIME_HI=1 (carry); write MTIME_LO in a cycle that also increments → it reads back the written value.
- CMP_HI=0, CMP_LO=10, CTRL=3, `mtime`=0 → `timer_irq` rises 1 edge after `mtime` reaches 10; write CMP_LO=100 → `timer_irq` falls.
- Read 0x02, then write 0x40 → each gives ERR1 (`hready`=0, `hresp`=1) then ERR2 (`hready`=1, `hresp`=1); register contents unchanged.
- WAIT_CYCLES=2 with back-to-back reads of 0x10 and 0x14 → `hready` sequence 0,0,1,0,0,1; assert `rstn` during WAIT → next cycle IDLE, `hready`=1, all registers at reset values.

Source files
------------

// File: rtl/ahb_timer_slave_if.sv
// AHB-lite slave-side signal bundle used by the machine timer responder.
interface ahb_timer_slave_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
);
  logic [AHB_ADDR_WIDTH-1:0] haddr;
  logic                      hwrite;
  logic [AHB_DATA_WIDTH-1:0] hwdata;
  logic                      hsel;
  logic                      hready;
  logic                      hresp;
  logic [AHB_DATA_WIDTH-1:0] hrdata;

  modport master (output haddr, hwrite, hwdata, hsel,
                  input  hready, hresp, hrdata);
  modport slave  (input  haddr, hwrite, hwdata, hsel,
                  output hready, hresp, hrdata);
endinterface

// File: rtl/ahb_timer_slave.sv
// AHB-lite machine timer responder: 64-bit mtime/mtimecmp, enable/interrupt
// control, prescaler, configurable wait states and two-cycle ERROR response.
// Read data is taken from the register values as they stand after the edge
// that enters RESP, so a write completing on that same edge is visible.
module ahb_timer_slave #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int WAIT_CYCLES    = 0,
  parameter int PRESCALE_RST   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  ahb_timer_slave_if.slave ahb,
  output logic             timer_irq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RESP = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  localparam logic [3:0]  C_WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [15:0] C_PRE_RST   = 16'(PRESCALE_RST);

  localparam logic [7:0] A_MTIME_LO = 8'h00;
  localparam logic [7:0] A_MTIME_HI = 8'h04;
  localparam logic [7:0] A_CMP_LO   = 8'h08;
  localparam logic [7:0] A_CMP_HI   = 8'h0C;
  localparam logic [7:0] A_CTRL     = 8'h10;
  localparam logic [7:0] A_PRESCALE = 8'h14;
  localparam logic [7:0] A_STATUS   = 8'h18;
  localparam logic [7:0] A_NONE     = 8'hFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [7:0]  r_addr;
  logic        r_write;
  logic        r_hready;
  logic        r_hresp;
  logic [31:0] r_hrdata;
  logic        r_irq;
  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic [1:0]  r_ctrl;
  logic [15:0] r_pre;
  logic [15:0] r_pre_cnt;

  logic        w_accept;
  logic        w_legal;
  logic        w_wr_en;
  logic        w_tick;
  logic        w_load_rd;
  logic        w_hready_nxt;
  logic        w_hresp_nxt;
  logic [7:0]  w_rd_addr;
  logic [31:0] w_rd_data;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_cmp_nxt;
  logic [1:0]  w_ctrl_nxt;
  logic [15:0] w_pre_nxt;
  logic [15:0] w_pre_cnt_nxt;
  logic        w_unused_haddr;

  // Word-aligned offsets 0x00..0x18 are the only mapped locations.
  function automatic logic is_legal(input logic [7:0] a);
    return (a[1:0] == 2'b00) && (a <= A_STATUS);
  endfunction

  assign w_unused_haddr = ^ahb.haddr[AHB_ADDR_WIDTH-1:8];
  assign w_legal   = is_legal(ahb.haddr[7:0]);
  assign w_accept  = ahb.hsel && ((r_state == S_IDLE) || (r_state == S_RESP) || (r_state == S_ERR2));
  assign w_wr_en   = (r_state == S_RESP) && r_write;
  assign w_tick    = r_ctrl[0] && (r_pre_cnt == r_pre);
  assign w_rd_addr = w_accept ? ahb.haddr[7:0] : r_addr;
  assign w_load_rd = (w_state_nxt == S_RESP) && (w_accept ? !ahb.hwrite : !r_write);

  // Next-state decode and the bus response that the next state presents.
  always_comb begin
    w_state_nxt  = r_state;
    w_hready_nxt = 1'b1;
    w_hresp_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_RESP, S_ERR2: begin
        if (!ahb.hsel) begin
          w_state_nxt = S_IDLE;
        end else if (!w_legal) begin
          w_state_nxt = S_ERR1;
        end else if (WAIT_CYCLES > 0) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == C_WAIT_LAST) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_WAIT:  w_hready_nxt = 1'b0;
      S_ERR1: begin
        w_hready_nxt = 1'b0;
        w_hresp_nxt  = 1'b1;
      end
      S_ERR2:  w_hresp_nxt = 1'b1;
      default: w_hresp_nxt = 1'b0;
    endcase
  end

  // Timer advance followed by software writes; a write to an mtime half
  // overrides that cycle's increment and suppresses any carry.
  always_comb begin
    w_mtime_nxt   = r_mtime;
    w_cmp_nxt     = r_cmp;
    w_ctrl_nxt    = r_ctrl;
    w_pre_nxt     = r_pre;
    w_pre_cnt_nxt = r_pre_cnt;
    if (w_tick) begin
      w_pre_cnt_nxt = 16'd0;
      w_mtime_nxt   = r_mtime + 64'd1;
    end else if (r_ctrl[0]) begin
      w_pre_cnt_nxt = r_pre_cnt + 16'd1;
    end else begin
      w_pre_cnt_nxt = r_pre_cnt;
    end
    case (w_wr_en ? r_addr : A_NONE)
      A_MTIME_LO: w_mtime_nxt = {r_mtime[63:32], ahb.hwdata};
      A_MTIME_HI: w_mtime_nxt = {ahb.hwdata, r_mtime[31:0]};
      A_CMP_LO:   w_cmp_nxt   = {r_cmp[63:32], ahb.hwdata};
      A_CMP_HI:   w_cmp_nxt   = {ahb.hwdata, r_cmp[31:0]};
      A_CTRL:     w_ctrl_nxt  = ahb.hwdata[1:0];
      A_PRESCALE: begin
        w_pre_nxt     = ahb.hwdata[15:0];
        w_pre_cnt_nxt = 16'd0;
      end
      default:    w_ctrl_nxt  = r_ctrl;
    endcase
  end

  // Read multiplexer over the post-edge register values.
  always_comb begin
    case (w_rd_addr)
      A_MTIME_LO: w_rd_data = w_mtime_nxt[31:0];
      A_MTIME_HI: w_rd_data = w_mtime_nxt[63:32];
      A_CMP_LO:   w_rd_data = w_cmp_nxt[31:0];
      A_CMP_HI:   w_rd_data = w_cmp_nxt[63:32];
      A_CTRL:     w_rd_data = {30'd0, w_ctrl_nxt};
      A_PRESCALE: w_rd_data = {16'd0, w_pre_nxt};
      A_STATUS:   w_rd_data = {31'd0, (w_mtime_nxt >= w_cmp_nxt)};
      default:    w_rd_data = 32'd0;
    endcase
  end

  // FSM state register and registered hready/hresp.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hready <= w_hready_nxt;
      r_hresp  <= w_hresp_nxt;
    end
  end

  // Address-phase capture, wait-state counter and read data register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_addr     <= 8'd0;
      r_write    <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_hrdata   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= ahb.haddr[7:0];
        r_write <= ahb.hwrite;
      end
      r_wait_cnt <= (r_state == S_WAIT) ? (r_wait_cnt + 4'd1) : 4'd0;
      if (w_load_rd) begin
        r_hrdata <= w_rd_data;
      end
    end
  end

  // Timer registers and the level interrupt from current-cycle values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_mtime   <= 64'd0;
      r_cmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_ctrl    <= 2'd0;
      r_pre     <= C_PRE_RST;
      r_pre_cnt <= 16'd0;
      r_irq     <= 1'b0;
    end else begin
      r_mtime   <= w_mtime_nxt;
      r_cmp     <= w_cmp_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_pre     <= w_pre_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_irq     <= r_ctrl[1] && (r_mtime >= r_cmp);
    end
  end

  assign ahb.hready = r_hready;
  assign ahb.hresp  = r_hresp;
  assign ahb.hrdata = r_hrdata;
  assign timer_irq  = r_irq;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Randomized self-checking bench for ahb_timer_slave. Instance dut has no wait
// states and is checked against a cycle-level reference model of the timer
// registers; instance dut2 has two wait states and is checked with constants.
module tb_ahb_timer_slave;
  localparam int PRE_RST2 = 5;

  logic clk = 1'b0;
  logic rstn;
  logic rstn2;
  logic irq;
  logic irq2;
  int   n_checks;
  int   n_errors;

  always #5 clk = ~clk;

  ahb_timer_slave_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus ();
  ahb_timer_slave_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus2 ();

  ahb_timer_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .WAIT_CYCLES(0), .PRESCALE_RST(0))
    dut (.clk(clk), .rstn(rstn), .ahb(bus), .timer_irq(irq));
  ahb_timer_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .WAIT_CYCLES(2), .PRESCALE_RST(PRE_RST2))
    dut2 (.clk(clk), .rstn(rstn2), .ahb(bus2), .timer_irq(irq2));

  // reference model of dut's architectural state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [1:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [15:0] m_cnt;
  logic        m_irq;
  logic [31:0] m_hrdata;

  // pending burst for dut
  logic        b_wr   [8];
  logic [7:0]  b_addr [8];
  logic [31:0] b_data [8];
  int          b_n;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ctrl   = 2'd0;
    m_pre    = 16'd0;
    m_cnt    = 16'd0;
    m_irq    = 1'b0;
    m_hrdata = 32'd0;
  endtask

  // One clock edge of the timer: interrupt from old values, prescaled tick,
  // then an optional software write that wins over the tick.
  task automatic model_edge(input logic wr, input logic [7:0] a, input logic [31:0] d);
    logic [63:0] old_t = m_mtime;
    logic        irq_next = m_ctrl[1] && (m_mtime >= m_cmp);
    logic        due = m_ctrl[0] && (m_cnt == m_pre);
    if (m_ctrl[0]) m_cnt = due ? 16'd0 : m_cnt + 16'd1;
    if (due) m_mtime = m_mtime + 64'd1;
    if (wr) begin
      case (a)
        8'h00: m_mtime = {old_t[63:32], d};
        8'h04: m_mtime = {d, old_t[31:0]};
        8'h08: m_cmp[31:0] = d;
        8'h0C: m_cmp[63:32] = d;
        8'h10: m_ctrl = d[1:0];
        8'h14: begin m_pre = d[15:0]; m_cnt = 16'd0; end
        default: ;
      endcase
    end
    m_irq = irq_next;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_mtime[31:0];
      8'h04:   return m_mtime[63:32];
      8'h08:   return m_cmp[31:0];
      8'h0C:   return m_cmp[63:32];
      8'h10:   return {30'd0, m_ctrl};
      8'h14:   return {16'd0, m_pre};
      8'h18:   return (m_mtime >= m_cmp) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one edge, step the model, then sample dut's interrupt.
  task automatic edge_chk(input logic wr, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    check_val("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_chk(1'b0, 8'h00, 32'd0);
  endtask

  task automatic add(input logic wr, input logic [7:0] a, input logic [31:0] d);
    b_wr[b_n]   = wr;
    b_addr[b_n] = a;
    b_data[b_n] = d;
    b_n++;
  endtask

  // Issue the queued legal transfers back to back on dut.
  task automatic go();
    int n = b_n;
    bus.hsel   = 1'b1;
    bus.haddr  = {24'($urandom), b_addr[0]};
    bus.hwrite = b_wr[0];
    for (int i = 0; i < n; i++) begin
      if (i == 0) edge_chk(1'b0, 8'h00, 32'd0);
      else        edge_chk(b_wr[i-1], b_addr[i-1], b_data[i-1]);
      check_val("rsp_hready", 64'(bus.hready), 64'd1);
      check_val("rsp_hresp", 64'(bus.hresp), 64'd0);
      if (!b_wr[i]) begin
        m_hrdata = model_read(b_addr[i]);
        check_val($sformatf("rd_%02h", b_addr[i]), 64'(bus.hrdata), 64'(m_hrdata));
      end
      bus.hwdata = b_data[i];
      if (i + 1 < n) begin
        bus.haddr  = {24'($urandom), b_addr[i+1]};
        bus.hwrite = b_wr[i+1];
      end else begin
        bus.hsel   = 1'b0;
        bus.hwrite = 1'b0;
      end
    end
    edge_chk(b_wr[n-1], b_addr[n-1], b_data[n-1]);
    check_val("end_hready", 64'(bus.hready), 64'd1);
    b_n = 0;
  endtask

  // Illegal access on dut: ERR1 then ERR2 then idle; no state changes.
  task automatic err_xfer(input logic wr, input logic [7:0] a);
    bus.hsel   = 1'b1;
    bus.haddr  = {24'($urandom), a};
    bus.hwrite = wr;
    bus.hwdata = $urandom;
    edge_chk(1'b0, 8'h00, 32'd0);
    check_val("err1_hready", 64'(bus.hready), 64'd0);
    check_val("err1_hresp", 64'(bus.hresp), 64'd1);
    bus.hsel   = 1'b0;
    bus.hwrite = 1'b0;
    edge_chk(1'b0, 8'h00, 32'd0);
    check_val("err2_hready", 64'(bus.hready), 64'd1);
    check_val("err2_hresp", 64'(bus.hresp), 64'd1);
    check_val("err_hrdata_hold", 64'(bus.hrdata), 64'(m_hrdata));
    edge_chk(1'b0, 8'h00, 32'd0);
    check_val("post_err_hresp", 64'(bus.hresp), 64'd0);
  endtask

  // Single transfer on dut2 (two wait states): hready 0,0,1 then write lands.
  task automatic xfer2(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp);
    bus2.hsel   = 1'b1;
    bus2.haddr  = {24'd0, a};
    bus2.hwrite = wr;
    bus2.hwdata = d;
    for (int k = 0; k < 3; k++) begin
      edge_chk(1'b0, 8'h00, 32'd0);
      if (k == 0) bus2.hsel = 1'b0;
      check_val("w2_hready", 64'(bus2.hready), (k == 2) ? 64'd1 : 64'd0);
    end
    if (!wr) check_val($sformatf("w2_rd_%02h", a), 64'(bus2.hrdata), 64'(exp));
    edge_chk(1'b0, 8'h00, 32'd0);
    check_val("w2_idle_hready", 64'(bus2.hready), 64'd1);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd;
    logic [31:0] prev;
    logic        rwr;
    int          len;
    int          idx;

    n_checks = 0;
    n_errors = 0;
    b_n      = 0;
    bus.hsel  = 1'b0; bus.haddr  = 32'd0; bus.hwrite  = 1'b0; bus.hwdata  = 32'd0;
    bus2.hsel = 1'b0; bus2.haddr = 32'd0; bus2.hwrite = 1'b0; bus2.hwdata = 32'd0;
    rstn  = 1'b1;
    rstn2 = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rstn  = 1'b0;
    rstn2 = 1'b0;
    check_val("rst_hready", 64'(bus.hready), 64'd1);
    check_val("rst_hresp", 64'(bus.hresp), 64'd0);
    check_val("rst_hrdata", 64'(bus.hrdata), 64'd0);
    check_val("rst_irq", 64'(irq), 64'd0);

    // reset values through the bus
    add(1'b0, 8'h0C, 32'd0); add(1'b0, 8'h10, 32'd0); go();

    // two wait states: single transfers, back-to-back reads, reset in WAIT
    xfer2(1'b1, 8'h08, 32'h0000_1234, 32'd0);
    xfer2(1'b0, 8'h08, 32'd0, 32'h0000_1234);
    bus2.hsel = 1'b1; bus2.haddr = 32'h10; bus2.hwrite = 1'b0;
    for (int k = 0; k < 6; k++) begin
      edge_chk(1'b0, 8'h00, 32'd0);
      check_val("b2b_hready", 64'(bus2.hready), (k % 3 == 2) ? 64'd1 : 64'd0);
      if (k == 2) begin
        check_val("b2b_rd_ctrl", 64'(bus2.hrdata), 64'd0);
        bus2.haddr = 32'h14;
      end
      if (k == 5) begin
        check_val("b2b_rd_pre", 64'(bus2.hrdata), 64'(PRE_RST2));
        bus2.haddr = 32'h08;
      end
    end
    edge_chk(1'b0, 8'h00, 32'd0);
    check_val("rst_wait_hready", 64'(bus2.hready), 64'd0);
    rstn2 = 1'b1;
    bus2.hsel = 1'b0;
    edge_chk(1'b0, 8'h00, 32'd0);
    rstn2 = 1'b0;
    check_val("rst2_hready", 64'(bus2.hready), 64'd1);
    check_val("rst2_hresp", 64'(bus2.hresp), 64'd0);
    check_val("rst2_hrdata", 64'(bus2.hrdata), 64'd0);
    check_val("rst2_irq", 64'(irq2), 64'd0);
    xfer2(1'b0, 8'h08, 32'd0, 32'hFFFF_FFFF);
    xfer2(1'b0, 8'h14, 32'd0, 32'(PRE_RST2));

    // prescale by 4: reads spaced 20 edges apart advance by exactly 5
    add(1'b1, 8'h14, 32'd3); add(1'b1, 8'h10, 32'd1); go();
    prev = 32'd0;
    for (int k = 0; k < 4; k++) begin
      idle(18);
      add(1'b0, 8'h00, 32'd0); go();
      if (k > 0) check_val("pre_delta", 64'(bus.hrdata - prev), 64'd5);
      prev = bus.hrdata;
    end

    // carry from low to high word, then write priority over increment
    add(1'b1, 8'h10, 32'd0); add(1'b1, 8'h14, 32'd0);
    add(1'b1, 8'h00, 32'hFFFF_FFFF); add(1'b1, 8'h04, 32'd0);
    add(1'b1, 8'h10, 32'd1); add(1'b0, 8'h00, 32'd0); add(1'b0, 8'h04, 32'd0); go();
    check_val("carry_hi", 64'(bus.hrdata), 64'd1);
    add(1'b1, 8'h00, 32'h5555_0000); add(1'b0, 8'h00, 32'd0); go();
    check_val("wr_prio", 64'(bus.hrdata), 64'h5555_0000);

    // compare interrupt rises, then falls after moving the compare value
    add(1'b1, 8'h10, 32'd0); add(1'b1, 8'h14, 32'd0); add(1'b1, 8'h00, 32'd0);
    add(1'b1, 8'h04, 32'd0); add(1'b1, 8'h0C, 32'd0); add(1'b1, 8'h08, 32'd10);
    add(1'b1, 8'h10, 32'd3); go();
    idle(15);
    check_val("irq_hi", 64'(irq), 64'd1);
    add(1'b1, 8'h08, 32'd100); go();
    idle(1);
    check_val("irq_lo", 64'(irq), 64'd0);

    // error responses leave all registers untouched
    err_xfer(1'b0, 8'h02);
    err_xfer(1'b1, 8'h40);
    for (int k = 0; k < 7; k++) add(1'b0, 8'(k * 4), 32'd0);
    go();

    // randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        do ra = 8'($urandom); while ((ra[1:0] == 2'b00) && (ra <= 8'h18));
        err_xfer(1'($urandom), ra);
      end else begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          idx = $urandom_range(0, 6);
          ra  = 8'(idx * 4);
          rwr = 1'($urandom);
          case (ra)
            8'h00:   rd = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                                      : 32'($urandom_range(0, 40));
            8'h04:   rd = 32'($urandom_range(0, 1));
            8'h08:   rd = 32'($urandom_range(0, 60));
            8'h0C:   rd = 32'($urandom_range(0, 1));
            8'h14:   rd = {16'($urandom), 16'($urandom_range(0, 3))};
            default: rd = $urandom;
          endcase
          add(rwr, ra, rd);
        end
        go();
        idle($urandom_range(0, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
